cache_arbiter: RTL
==================

// Module: cache_arbiter
// PURPOSE
//  Shares the single physical-memory port between I-cache and D-cache line fills/writebacks.
//  Sits below both caches and above pmem.
//  One request is outstanding at a time; FSM grants one cache, passes its request through,
//  and routes pmem_resp back. Fair alternation when both caches request together.
// PARAMETERS
//  LINE_W   256  cacheline width in bits (pmem data bus)
//  ADDR_W   32   physical address width
// PORTS
//  clk            in   1       system clock; all state updates on rising edge
//  rst            in   1       synchronous, active-high reset
//  icache_read    in   1       I-cache line-fill request; held until icache_resp
//  icache_addr    in   ADDR_W  I-cache line address, stable while icache_read
//  icache_resp    out  1       one-cycle completion pulse to I-cache
//  dcache_read    in   1       D-cache line-fill request; held until dcache_resp
//  dcache_write   in   1       D-cache writeback request; held until dcache_resp
//  dcache_addr    in   ADDR_W  D-cache line address, stable while requesting
//  dcache_wdata   in   LINE_W  writeback line
//  dcache_resp    out  1       one-cycle completion pulse to D-cache
//  line_rdata     out  LINE_W  pmem_rdata broadcast to both caches (valid with *_resp)
//  pmem_read      out  1       read to memory
//  pmem_write     out  1       write to memory
//  pmem_addr      out  ADDR_W  address to memory
//  pmem_wdata     out  LINE_W  write data to memory
//  pmem_resp      in   1       one-cycle completion pulse from memory
//  pmem_rdata     in   LINE_W  fill data, valid with pmem_resp
//  arbiter_state  out  2       current FSM state (debug/trace)
// BEHAVIOUR
//  States (2-bit enum): ARB_IDLE=00, ARB_ICACHE=01, ARB_DCACHE=10; 11 unreachable -> IDLE.
//  Reset: state=ARB_IDLE, last_grant=ICACHE; all outputs 0 in the cycle after rst edge.
//  Outputs are Moore-decoded from registered state plus combinational data muxes:
//   IDLE: pmem_read=pmem_write=0, pmem_addr=0, *_resp=0.
//   ICACHE: pmem_read=1, pmem_addr=icache_addr, icache_resp=pmem_resp.
//   DCACHE: pmem_read=dcache_read, pmem_write=dcache_write, pmem_addr=dcache_addr,
//           pmem_wdata=dcache_wdata, dcache_resp=pmem_resp.
//   Non-granted cache's resp is 0 always; line_rdata=pmem_rdata in all states.
//  IDLE transitions (evaluated each cycle):
//   only I pending -> ICACHE; only D pending (read|write) -> DCACHE.
//   both pending -> grant the one NOT equal to last_grant (first tie after reset -> D).
//   none -> stay IDLE.
//  ICACHE/DCACHE: stay until pmem_resp=1, then -> IDLE next edge and last_grant<=served.
//  Latency: request seen in IDLE at cycle n -> pmem_read/write high at n+1.
//   pmem_resp at m -> cache resp at m (same cycle), IDLE at m+1, next grant earliest m+2.
//   The IDLE cycle lets the served cache drop its request before re-arbitration.
//  Boundaries:
//   pmem_resp while IDLE: ignored, no resp pulsed.
//   Granted cache drops its request before pmem_resp: grant held until pmem_resp (protocol
//    violation; assertion fires).
//   dcache_read & dcache_write both high: illegal; assertion fires. Pass-through still forwards
//    both strobes.
//   rst asserted mid-transaction: next edge -> IDLE, strobes drop. In-flight pmem response is
//    discarded (memory model is reset too).
//   No starvation: with both requesting continuously, grants strictly alternate.
// STRUCTURE
//  Package arbiter_types: arb_state_t enum, grant_t {GRANT_I, GRANT_D}, LINE_W/ADDR_W
//  defaults.
//  Single module: one state register + last_grant flop, next-state always_comb, output
//  always_comb. No sub-module; the tie-break is two gates.
//  Assertions: one-hot pmem strobes, resp only to granted cache, request held while granted.
// TESTING
//  1. I-only: icache_read=1, addr=0x0000_1000; pmem_resp after 5 cycles -> pmem_read=1,
//     pmem_addr=0x1000, icache_resp pulses 1 cycle with line_rdata=pmem_rdata, state 01->00.
//  2. D writeback: dcache_write=1, addr=0x0000_2040, wdata=0xA5..A5 -> pmem_write=1,
//     pmem_wdata matches, dcache_resp single pulse, icache_resp stays 0.
//  3. Tie after reset: I and D raised same cycle -> DCACHE first. After its resp, 1 IDLE
//     cycle, then ICACHE.
//  4. Fairness: both held continuously for 6 transactions -> grants D,I,D,I,D,I.
//     Each separated by exactly one IDLE cycle.
//  5. Spurious pmem_resp in IDLE -> no *_resp, state stays 00.
//  6. rst mid-DCACHE read (cycle 3 of 6) -> next cycle state=00, pmem_read=0;
//     late pmem_resp ignored.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D-cache to physical-memory arbiter.
package arbiter_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_ICACHE = 2'b01,
    ARB_DCACHE = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache, one request at a time,
// alternating grants when both caches are waiting.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_W = arbiter_types::LINE_W,
  parameter int ADDR_W = arbiter_types::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_resp,
  output logic [LINE_W-1:0] line_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [1:0]        arbiter_state
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       dcache_req;

  assign dcache_req = dcache_read | dcache_write;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (icache_read && dcache_req)
          state_d = (last_grant_q == GRANT_I) ? ARB_DCACHE : ARB_ICACHE;
        else if (icache_read)
          state_d = ARB_ICACHE;
        else if (dcache_req)
          state_d = ARB_DCACHE;
      end
      ARB_ICACHE: begin
        if (pmem_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_I;
        end
      end
      ARB_DCACHE: begin
        if (pmem_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_D;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_addr   = '0;
    pmem_wdata  = '0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    unique case (state_q)
      ARB_ICACHE: begin
        pmem_read   = 1'b1;
        pmem_addr   = icache_addr;
        icache_resp = pmem_resp;
      end
      ARB_DCACHE: begin
        pmem_read   = dcache_read;
        pmem_write  = dcache_write;
        pmem_addr   = dcache_addr;
        pmem_wdata  = dcache_wdata;
        dcache_resp = pmem_resp;
      end
      default: ;
    endcase
  end

  assign line_rdata    = pmem_rdata;
  assign arbiter_state = state_q;

  // Protocol checks: a D-cache asserting read and write together, or a granted cache
  // withdrawing its request before completion, is a caller bug.
  a_strobe_onehot : assert property (@(posedge clk) disable iff (rst)
    !(pmem_read && pmem_write));

  a_resp_granted : assert property (@(posedge clk) disable iff (rst)
    (!icache_resp || state_q == ARB_ICACHE) && (!dcache_resp || state_q == ARB_DCACHE));

  a_req_held : assert property (@(posedge clk) disable iff (rst)
    (state_q != ARB_ICACHE || icache_read) && (state_q != ARB_DCACHE || dcache_req));

endmodule
